// File: rtl/fifo_async_pkg.sv
// fifo_async_pkg: pointer-width and Gray-code helpers shared by both FIFO clock domains
package fifo_async_pkg;

    localparam int PTR_MAX = 32;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing a Gray pointer into the local clock domain
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_r,
    input  logic         rst_r,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync1;

    // first flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/wptr_and_full_async.sv
// wptr_and_full_async: write-side pointer, full/almost-full flags and fill level of an async FIFO
module wptr_and_full_async
    import fifo_async_pkg::*;
#(
    parameter  int width        = 32,
    parameter  int depth        = 1024,
    parameter  int afull_margin = 4,
    localparam int A            = $clog2(depth),
    localparam int P            = ptr_width(depth)
) (
    input  logic         clk_w,
    input  logic         rst_w,
    input  logic         write_enable,
    input  logic [P-1:0] rptr_gray,
    output logic [P-1:0] wptr,
    output logic [P-1:0] wptr_gray,
    output logic         wr_en,
    output logic         full,
    output logic         almost_full,
    output logic [P-1:0] fill_level,
    output logic         overflow
);

    if (width < 1) begin : g_bad_width
        $error("width must be at least 1");
    end
    if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $error("depth must be a power of two");
    end
    if (afull_margin < 1 || afull_margin >= depth) begin : g_bad_margin
        $error("afull_margin must be in 1..depth-1");
    end

    logic [P-1:0] sync2;
    logic [P-1:0] rptr_bin_sync;
    logic [P-1:0] wptr_next;
    logic [P-1:0] free_slots;

    sync_2ff #(.W(P)) u_rptr_sync (
        .clk_r (clk_w),
        .rst_r (rst_w),
        .d     (rptr_gray),
        .q     (sync2)
    );

    // flags derive only from the synchronized read pointer, so they lag reads and stay pessimistic
    always_comb begin
        rptr_bin_sync = P'(gray2bin(PTR_MAX'(sync2)));
        full          = (wptr[P-1] != rptr_bin_sync[P-1]) && (wptr[A-1:0] == rptr_bin_sync[A-1:0]);
        wr_en         = write_enable && !full;
        wptr_next     = wptr + P'(wr_en);
        fill_level    = wptr - rptr_bin_sync;
        free_slots    = P'(depth) - fill_level;
        almost_full   = full || (free_slots <= P'(afull_margin));
    end

    // Gray pointer is registered from the next binary value so it never glitches on the crossing
    always_ff @(posedge clk_w) begin
        if (rst_w) begin
            wptr      <= '0;
            wptr_gray <= '0;
            overflow  <= 1'b0;
        end else begin
            wptr      <= wptr_next;
            wptr_gray <= P'(bin2gray(PTR_MAX'(wptr_next)));
            overflow  <= overflow | (write_enable & full);
        end
    end

endmodule

// File: tb/tb_wptr_and_full_async.sv
// tb_wptr_and_full_async: directed stimulus with a queued scoreboard checked at each falling edge
module tb_wptr_and_full_async;

    localparam logic [6:0] ALL = 7'h7f;

    logic       clk_w = 1'b0;
    logic       rst_w = 1'b1;
    logic       write_enable = 1'b0;
    logic [3:0] rptr_gray = 4'd0;
    logic [3:0] wptr, wptr_gray, fill_level;
    logic       wr_en, full, almost_full, overflow;

    typedef struct {
        string      nm;
        logic [6:0] m;
        logic [3:0] wp;
        logic [3:0] wg;
        logic [3:0] fill;
        logic       full;
        logic       af;
        logic       ov;
        logic       wen;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    wptr_and_full_async #(.width(8), .depth(8), .afull_margin(2)) dut (
        .clk_w        (clk_w),
        .rst_w        (rst_w),
        .write_enable (write_enable),
        .rptr_gray    (rptr_gray),
        .wptr         (wptr),
        .wptr_gray    (wptr_gray),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .fill_level   (fill_level),
        .overflow     (overflow)
    );

    always #5 clk_w = ~clk_w;

    function automatic logic [3:0] tb_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] tb_bin(input logic [3:0] gv);
        logic [3:0] b;
        b[3] = gv[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ gv[i];
        return b;
    endfunction

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_w) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.m[0]) cmp({e.nm, ".wptr"}, wptr, e.wp);
            if (e.m[1]) cmp({e.nm, ".wptr_gray"}, wptr_gray, e.wg);
            if (e.m[2]) cmp({e.nm, ".full"}, 4'(full), 4'(e.full));
            if (e.m[3]) cmp({e.nm, ".almost_full"}, 4'(almost_full), 4'(e.af));
            if (e.m[4]) cmp({e.nm, ".fill_level"}, fill_level, e.fill);
            if (e.m[5]) cmp({e.nm, ".overflow"}, 4'(overflow), 4'(e.ov));
            if (e.m[6]) cmp({e.nm, ".wr_en"}, 4'(wr_en), 4'(e.wen));
        end
    end

    task automatic step(input logic r, input logic we, input logic [3:0] rg, input string nm,
                        input logic [6:0] m, input logic [3:0] wp, input logic [3:0] wg,
                        input logic [3:0] fill, input logic fl, input logic af,
                        input logic ov, input logic wen);
        @(posedge clk_w);
        #1;
        rst_w        = r;
        write_enable = we;
        rptr_gray    = rg;
        sb.push_back('{nm, m, wp, wg, fill, fl, af, ov, wen});
    endtask

    initial begin
        logic [3:0] w, wm, h1, h2, rg, fill;
        step(1'b1, 1'b0, 4'd0, "rst", ALL, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd0, "rst_wen", ALL, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd0, "wr0", ALL, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            w = 4'(i);
            step(1'b0, 1'b1, 4'd0, "fillup", ALL, w, tb_gray(w), w, i == 8, i >= 6, 1'b0, i != 8);
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 4'd0, "ovf", ALL, 4'd8, 4'hc, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, "ovf_hold", ALL, 4'd8, 4'hc, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0010, "rd_edge0", ALL, 4'd8, 4'hc, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0010, "rd_edge1", ALL, 4'd8, 4'hc, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0010, "rd_edge2", ALL, 4'd8, 4'hc, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        h2 = 4'b0010;
        h1 = 4'b0010;
        wm = 4'd8;
        for (int j = 1; j <= 21; j++) begin
            rg   = (j <= 12) ? tb_gray(wm) : 4'b0010;
            fill = wm - tb_bin(h2);
            step(1'b0, 1'b1, rg, (j <= 12) ? "wrap" : "refill", ALL, wm, tb_gray(wm), fill,
                 fill == 4'd8, (4'd8 - fill) <= 4'd2, 1'b1, fill != 4'd8);
            h2 = h1;
            h1 = rg;
            if (fill != 4'd8) wm = wm + 4'd1;
        end
        step(1'b1, 1'b1, 4'b0010, "rst_full", ALL, 4'd11, 4'b1110, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4'b0010, "rst_pri", ALL, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0010, "rst_done", ALL, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk_w);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
